uart_rx_fifo_receiver: RTL and testbench
========================================

// Module: uart_rx_fifo_receiver
// PURPOSE
//  Byte-oriented UART receiver: 8N1, LSB first, with a show-ahead receive FIFO.
//  Receiving end of the probe's host serial link. Consumes the rx pin in the clk_main domain
//  (32.4 MHz) and hands bytes to the CPU bus / command parser in main.
//  Bit timing uses the same divider parameters as the UART transmitter (281 -> 115200 baud @ 32.4 MHz).
// PARAMETERS
//  CLOCK_DIV            281  clk cycles per bit period; must be >= 4
//  CLOCK_COUNTER_BITS   9    width of the bit-period counter; must hold CLOCK_DIV-1
//  FIFO_DEPTH_BITS      3    log2 of FIFO depth (8 entries)
// PORTS
//  clk            in   1  system clock (clk_main)
//  rst            in   1  asynchronous reset, active-high
//  rx             in   1  serial input, asynchronous, idle high
//  rd             in   1  pop head byte; ignored when empty
//  data_out       out  8  FIFO head byte; valid while !empty
//  empty          out  1  FIFO empty
//  full           out  1  FIFO full
//  overflow       out  1  1-cycle pulse: completed byte dropped because FIFO full
//  frame_error    out  1  1-cycle pulse: stop bit sampled low, byte discarded
//  parity_error   out  1  1-cycle pulse (UART_RX_PARITY_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: empty=1, full=0, data_out=0, all pulses=0; state IDLE; sync flops=1; FIFO pointers=0.
//  - rx passes through a 2-flop synchronizer (reset to 1); rx_s is the 2nd flop, rx_p is rx_s delayed 1 cycle.
//  - FSM:
//    IDLE: on falling edge (rx_p=1, rx_s=0), cnt<=CLOCK_DIV/2 -> START. A line held low does not retrigger.
//    START: at cnt==0, rx_s=0 -> DATA with cnt<=CLOCK_DIV-1, bit=0. rx_s=1 is a glitch -> IDLE, no pulse.
//    DATA: at cnt==0, shift rx_s into shreg MSB (LSB first on the wire) and reload cnt.
//          After bit 7 -> PARITY (if enabled) else STOP.
//    STOP: at cnt==0, rx_s=1 -> push shreg. rx_s=0 -> frame_error pulse, no push. Both -> IDLE.
//  - Otherwise cnt decrements by 1 each cycle.
//  - Sampling is mid-bit. rx falling edge to push is ~(9.5*CLOCK_DIV+3) cycles.
//  - FIFO is show-ahead: data_out = mem[rd_ptr]; a pop updates data_out on the next cycle.
//  - Occupancy count is FIFO_DEPTH_BITS+1 wide; pointers wrap modulo depth.
//  - Push while full and no rd: byte dropped, overflow pulses, FIFO unchanged.
//  - Push and rd in the same cycle: both succeed, count unchanged. This holds when full and when
//    non-empty; empty+rd+push is a push only.
//  - rd while empty: no effect, no error.
//  - Reset asserted mid-frame: frame abandoned and FIFO cleared at once. After release, the receiver
//    waits for a fresh falling edge.
// CONFIGURATION
//  `UART_RX_PARITY_EN defined: an even-parity bit follows bit 7. The PARITY state samples it at cnt==0.
//    XOR of data and parity != 0 -> parity_error pulse at STOP and the byte is not pushed.
//    A frame error takes precedence: only frame_error pulses.
//  Undefined: no parity state, frame is 8N1, parity_error tied 0.
// STRUCTURE
//  - Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and the default CLOCK_DIV
//    constant, shared with the UART transmitter.
//  - One sub-module, uart_rx_fifo: synchronous-write, show-ahead FIFO with push/pop/full/empty/overflow.
//    Reusable by the SPI display path.
//  - This file holds the synchronizer, the bit-timing counter and the FSM.
// TESTING (CLOCK_DIV=281, bit period 281 clk)
//  1. Send 0x55 8N1 -> after ~2670 cycles empty=0, data_out=0x55. rd for 1 cycle -> empty=1 next cycle.
//  2. rx low pulse of 100 cycles, then high -> no push, no pulses, FSM back in IDLE.
//  3. Send 0xA3 with stop bit forced 0 -> frame_error for exactly 1 cycle, empty stays 1.
//     A following 0x3C is still received correctly.
//  4. Send 9 bytes 0x00..0x08 without rd -> full=1 after the 8th byte.
//     9th byte: overflow pulses once. Reads return 0x00..0x07 in order.
//  5. Fill to 8, then assert rd in the same cycle as the 9th byte's push ->
//     no overflow, count stays 8, last entry = 0x08.
//  6. Assert rst during bit 4 of a frame -> empty=1 at once.
//     With UART_RX_PARITY_EN, send 0x07 with wrong parity -> parity_error pulse, no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, default bit divider
// and the parity helper.
package uart_pkg;

  localparam int CLOCK_DIV_DEFAULT = 281;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Returns 1 when the data byte plus its parity bit carry an odd number of ones.
  function automatic logic parity_odd(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous-write, show-ahead FIFO: the head entry is always visible on data_o.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH_BITS = 3,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int DEPTH_N = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] COUNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] COUNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [DEPTH_N];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  empty_q, full_q, overflow_q, overflow_d;
  logic                  do_push_s, do_pop_s;

  always_comb begin
    do_pop_s   = pop_i && (count_q != {(DEPTH_BITS+1){1'b0}});
    do_push_s  = push_i && ((count_q != COUNT_FULL) || do_pop_s);
    overflow_d = push_i && (count_q == COUNT_FULL) && !pop_i;
    wr_ptr_d   = do_push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = do_pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_N; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q   <= {DEPTH_BITS{1'b0}};
      rd_ptr_q   <= {DEPTH_BITS{1'b0}};
      count_q    <= {(DEPTH_BITS+1){1'b0}};
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == {(DEPTH_BITS+1){1'b0}});
      full_q     <= (count_d == COUNT_FULL);
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// 8N1 UART receiver with show-ahead receive FIFO; defining UART_RX_PARITY_EN
// adds an even-parity bit after bit 7 and enables parity_error.
module uart_rx_fifo_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_DIV          = CLOCK_DIV_DEFAULT,
  parameter int CLOCK_COUNTER_BITS = 9,
  parameter int FIFO_DEPTH_BITS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_error,
  output logic       parity_error
);

  localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_HALF   = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2);
  localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_RELOAD = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
  localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_ZERO   = {CLOCK_COUNTER_BITS{1'b0}};
  localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_ONE    = {{(CLOCK_COUNTER_BITS-1){1'b0}}, 1'b1};

  logic                          sync1_q, rx_s_q, rx_p_q;
  uart_state_e                   state_q, state_d;
  logic [CLOCK_COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]                    bit_q, bit_d;
  logic [7:0]                    shreg_q, shreg_d;
  logic                          push_q, push_d;
  logic                          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                          par_q, par_d;
  logic                          perr_q, perr_d;
`endif

  // rx is asynchronous: two flops for metastability, a third for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
    end
  end

  // Next-state logic; the counter only runs while a frame is in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_p_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_ZERO) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = CNT_RELOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_ZERO) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = CNT_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CNT_ZERO) begin
          par_d   = rx_s_q;
          cnt_d   = CNT_RELOAD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
          // A low stop bit wins over any parity outcome.
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            if (parity_odd(shreg_q, par_q)) begin
              perr_d = 1'b1;
            end else begin
              push_d = 1'b1;
            end
`else
            push_d = 1'b1;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH_BITS (FIFO_DEPTH_BITS),
    .WIDTH      (8)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .push_data_i (shreg_q),
    .pop_i       (rd),
    .data_o      (data_out),
    .empty_o     (empty),
    .full_o      (full),
    .overflow_o  (overflow)
  );

  assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// Directed bench for uart_rx_fifo_receiver; honours UART_RX_PARITY_EN for frame shape.
module tb_uart_rx_fifo_receiver;

  localparam int DIV = 281;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 10 + PAR_BITS;
  // Frame-relative negedge index at which push_q is high (write on the following posedge).
  localparam int PUSH_CYC = 4 + DIV / 2 + (9 + PAR_BITS) * DIV;

  logic       clk = 1'b0;
  logic       rst, rx, rd;
  logic [7:0] data_out;
  logic       empty, full, overflow, frame_error, parity_error;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;

  uart_rx_fifo_receiver #(
    .CLOCK_DIV          (DIV),
    .CLOCK_COUNTER_BITS (9),
    .FIFO_DEPTH_BITS    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rd           (rd),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow)     ovf_cnt <= ovf_cnt + 1;
    if (frame_error)  fe_cnt  <= fe_cnt + 1;
    if (parity_error) pe_cnt  <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; rd pulses on negedge rd_cyc, and abort_cyc stops driving mid-frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int rd_cyc, input int abort_cyc);
    int slot;
    for (int cyc = 0; cyc < NBITS * DIV + 20; cyc++) begin
      @(negedge clk);
      if (cyc == abort_cyc) return;
      slot = cyc / DIV;
      if (slot == 0)              rx = 1'b0;
      else if (slot <= 8)         rx = b[slot-1];
      else if (slot == NBITS - 1) rx = stop_bit;
      else if (slot < NBITS - 1)  rx = (^b) ^ par_flip;
      else                        rx = 1'b1;
      rd = (cyc == rd_cyc);
    end
    rd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, data_out}, {24'd0, exp});
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'h00);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ferr", {31'd0, frame_error}, 32'd0);
    check("rst_perr", {31'd0, parity_error}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: single byte, then pop
    send_byte(8'h55);
    check("t1_nonempty", {31'd0, empty}, 32'd0);
    pop_expect("t1_data", 8'h55);
    check("t1_empty_after_rd", {31'd0, empty}, 32'd1);

    // 2: short low glitch
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("t2_empty", {31'd0, empty}, 32'd1);
    check("t2_no_ferr", fe_cnt, 32'd0);
    check("t2_no_ovf", ovf_cnt, 32'd0);
    check("t2_no_perr", pe_cnt, 32'd0);

    // 3: stop bit low, then a good byte
    send_frame(8'hA3, 1'b0, 1'b0, -1, -1);
    check("t3_ferr_once", fe_cnt, 32'd1);
    check("t3_empty", {31'd0, empty}, 32'd1);
    send_byte(8'h3C);
    check("t3_next_nonempty", {31'd0, empty}, 32'd0);
    pop_expect("t3_next_data", 8'h3C);
    check("t3_empty_after", {31'd0, empty}, 32'd1);

    // 4: fill to 8, 9th overflows
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    check("t4_full", {31'd0, full}, 32'd1);
    check("t4_no_ovf_yet", ovf_cnt, 32'd0);
    send_byte(8'h08);
    check("t4_ovf_once", ovf_cnt, 32'd1);
    check("t4_still_full", {31'd0, full}, 32'd1);
    check("t4_head", {24'd0, data_out}, 32'h00);

    // 5: push coincident with rd while full
    send_frame(8'h08, 1'b1, 1'b0, PUSH_CYC, -1);
    check("t5_no_new_ovf", ovf_cnt, 32'd1);
    check("t5_full", {31'd0, full}, 32'd1);
    for (int i = 1; i <= 8; i++) pop_expect("t5_read", 8'(i));
    check("t5_empty", {31'd0, empty}, 32'd1);

    // 6: reset mid-frame
    send_byte(8'h5A);
    check("t6_nonempty", {31'd0, empty}, 32'd0);
    send_frame(8'hF0, 1'b1, 1'b0, -1, 5 * DIV + DIV / 2);
    rst = 1'b1;
    #1;
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    check("t6_rst_data", {24'd0, data_out}, 32'h00);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    check("t6_idle_empty", {31'd0, empty}, 32'd1);
    check("t6_no_ferr", fe_cnt, 32'd1);
    send_byte(8'h81);
    check("t6_after_nonempty", {31'd0, empty}, 32'd0);
    pop_expect("t6_after_data", 8'h81);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    check("par_err_once", pe_cnt, 32'd1);
    check("par_no_push", {31'd0, empty}, 32'd1);
    send_frame(8'h07, 1'b0, 1'b1, -1, -1);
    check("par_fe_precedence_fe", fe_cnt, 32'd2);
    check("par_fe_precedence_pe", pe_cnt, 32'd1);
    send_byte(8'h07);
    check("par_good_nonempty", {31'd0, empty}, 32'd0);
    pop_expect("par_good_data", 8'h07);
`else
    check("noparity_tied", pe_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
